// File: rtl/jpeg_capture_pkg.sv
// Shared types and helpers for the JPEG capture sequencer and its output pacer.
package jpeg_capture_pkg;

    localparam int MaxBytes = 8;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReset    = 3'd1,
        StWaitSof  = 3'd2,
        StCompress = 3'd3,
        StDone     = 3'd4,
        StError    = 3'd5
    } capture_state_t;

    // Reverses the order of the lowest n_bytes bytes; bytes above n_bytes come back as zero.
    function automatic logic [8*MaxBytes-1:0] byte_swap(input logic [8*MaxBytes-1:0] data,
                                                        input int n_bytes);
        logic [8*MaxBytes-1:0] swapped;
        swapped = '0;
        for (int i = 0; i < MaxBytes; i++) begin
            if (i < n_bytes) begin
                swapped[8*i +: 8] = data[8*(n_bytes-1-i) +: 8];
            end
        end
        return swapped;
    endfunction

endpackage

// File: rtl/jpeg_out_pacer.sv
// Paces encoder beats with a minimum idle gap and optionally reverses byte order.
module jpeg_out_pacer
    import jpeg_capture_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active_i,
    input  logic [8*DATA_BYTES-1:0] enc_data_i,
    input  logic                    enc_valid_i,
    output logic [8*DATA_BYTES-1:0] data_o,
    output logic                    data_valid_o,
    output logic                    enc_hold_o
);

    localparam int unsigned DataW = 8 * DATA_BYTES;

    logic [2:0] gap_q, gap_d;

    always_comb begin
        data_valid_o = enc_valid_i & active_i & (gap_q == 3'd0);
        enc_hold_o   = enc_valid_i & ~data_valid_o;
        gap_d        = gap_q;
        if (data_valid_o) begin
            gap_d = 3'(GAP_CYCLES);
        end else if (gap_q != 3'd0) begin
            gap_d = gap_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q <= 3'd0;
        end else begin
            gap_q <= gap_d;
        end
    end

    if (SWAP_BYTES) begin : g_swap
        logic [8*MaxBytes-1:0] data_wide;
        logic [8*MaxBytes-1:0] data_swapped;
        always_comb begin
            data_wide              = '0;
            data_wide[DataW-1:0]   = enc_data_i;
            data_swapped           = byte_swap(data_wide, int'(DATA_BYTES));
            data_o                 = data_swapped[DataW-1:0];
        end
    end else begin : g_pass
        assign data_o = enc_data_i;
    end

endmodule

// File: rtl/jpeg_capture_sequencer.sv
// Burst capture controller: sequences encoder reset/enable per frame, runs the watchdog
// and per-frame counters, and emits paced encoder output.
module jpeg_capture_sequencer
    import jpeg_capture_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MAX_FRAMES = 4,
    parameter int unsigned TIMEOUT_W  = 24,
    parameter int unsigned ADDR_W     = 16,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_capture_in,
    input  logic                               abort_in,
    input  logic [$clog2(MAX_FRAMES+1)-1:0]    frame_count_in,
    input  logic [TIMEOUT_W-1:0]               timeout_in,
    input  logic                               frame_valid_in,
    input  logic [8*DATA_BYTES-1:0]            enc_data_in,
    input  logic                               enc_valid_in,
    input  logic                               enc_last_in,
    output logic                               enc_hold_out,
    output logic                               enc_reset_out,
    output logic                               enc_en_out,
    output logic [8*DATA_BYTES-1:0]            data_out,
    output logic                               data_valid_out,
    output logic [ADDR_W-1:0]                  byte_count_out,
    output logic [$clog2(MAX_FRAMES+1)-1:0]    frames_done_out,
    output logic                               frame_done_out,
    output logic                               image_valid_out,
    output logic                               error_out,
    output logic                               busy_out
);

    localparam int unsigned FrameW = $clog2(MAX_FRAMES + 1);
    localparam int unsigned SumW   = ADDR_W + 1;
    localparam logic [FrameW-1:0] MaxFrames = FrameW'(MAX_FRAMES);

    capture_state_t        state_q, state_d;
    logic [FrameW-1:0]     target_q, target_d;
    logic [FrameW-1:0]     frames_done_q, frames_done_d;
    logic [FrameW-1:0]     frames_inc;
    logic [ADDR_W-1:0]     byte_count_q, byte_count_d;
    logic [SumW-1:0]       byte_sum;
    logic [TIMEOUT_W-1:0]  wdog_q, wdog_d, wdog_inc;
    logic                  frame_done_q, frame_done_d;
    logic                  beat, last_beat, expired;

    jpeg_out_pacer #(
        .DATA_BYTES (DATA_BYTES),
        .GAP_CYCLES (GAP_CYCLES),
        .SWAP_BYTES (SWAP_BYTES)
    ) u_pacer (
        .clk          (clk),
        .reset        (reset),
        .active_i     (state_q == StCompress),
        .enc_data_i   (enc_data_in),
        .enc_valid_i  (enc_valid_in),
        .data_o       (data_out),
        .data_valid_o (data_valid_out),
        .enc_hold_o   (enc_hold_out)
    );

    assign beat       = data_valid_out;
    assign last_beat  = beat & enc_last_in;
    assign expired    = (timeout_in != '0) && (wdog_q == timeout_in);
    assign wdog_inc   = (wdog_q == '1) ? wdog_q : wdog_q + TIMEOUT_W'(1);
    assign frames_inc = frames_done_q + FrameW'(1);
    assign byte_sum   = {1'b0, byte_count_q} + SumW'(DATA_BYTES);

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        frames_done_d = frames_done_q;
        byte_count_d  = byte_count_q;
        wdog_d        = '0;
        frame_done_d  = 1'b0;

        if (beat) begin
            byte_count_d = byte_sum[ADDR_W] ? '1 : byte_sum[ADDR_W-1:0];
        end

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_capture_in && (frame_count_in != '0)) begin
                    target_d      = (frame_count_in > MaxFrames) ? MaxFrames : frame_count_in;
                    frames_done_d = '0;
                    byte_count_d  = '0;
                    state_d       = StReset;
                end
            end
            StReset: begin
                byte_count_d = '0;
                if (!frame_valid_in) begin
                    state_d = StWaitSof;
                end
            end
            StWaitSof: begin
                wdog_d = wdog_inc;
                // Expiry is checked first so a late frame start cannot overrun the limit.
                if (expired) begin
                    state_d = StError;
                end else if (frame_valid_in) begin
                    state_d = StCompress;
                end
            end
            StCompress: begin
                wdog_d = beat ? '0 : wdog_inc;
                if (last_beat) begin
                    frame_done_d  = 1'b1;
                    frames_done_d = frames_inc;
                    state_d       = (frames_inc < target_q) ? StReset : StDone;
                end else if (expired && !beat) begin
                    state_d = StError;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort_in && (state_q inside {StReset, StWaitSof, StCompress})) begin
            state_d       = StIdle;
            frame_done_d  = 1'b0;
            frames_done_d = frames_done_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            target_q      <= '0;
            frames_done_q <= '0;
            byte_count_q  <= '0;
            wdog_q        <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            frames_done_q <= frames_done_d;
            byte_count_q  <= byte_count_d;
            wdog_q        <= wdog_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign enc_reset_out   = (state_q == StIdle) || (state_q == StReset) || (state_q == StError);
    assign enc_en_out      = (state_q == StWaitSof) || (state_q == StCompress);
    assign busy_out        = (state_q == StReset) || enc_en_out;
    assign image_valid_out = (state_q == StDone);
    assign error_out       = (state_q == StError);
    assign byte_count_out  = byte_count_q;
    assign frames_done_out = frames_done_q;
    assign frame_done_out  = frame_done_q;

endmodule

// File: tb/tb_jpeg_capture_sequencer.sv
// Scoreboard bench for jpeg_capture_sequencer: default instance plus a no-gap, no-swap instance.
module tb_jpeg_capture_sequencer;

    localparam int FW = 3;
    localparam int TW = 24;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          start, abort, fv, enc_valid, enc_last;
    logic [FW-1:0] fcount;
    logic [TW-1:0] timeout;
    logic [31:0]   enc_data;
    logic          hold, enc_rst, enc_en, dvalid, fd_pulse, img, err, busy;
    logic [31:0]   dout;
    logic [AW-1:0] bcount;
    logic [FW-1:0] fdone;

    logic          start_z, fv_z, enc_valid_z, enc_last_z;
    logic [FW-1:0] fcount_z;
    logic [31:0]   enc_data_z;
    logic          hold_z, enc_rst_z, enc_en_z, dvalid_z, fd_pulse_z, img_z, err_z, busy_z;
    logic [31:0]   dout_z;
    logic [AW-1:0] bcount_z;
    logic [FW-1:0] fdone_z;

    jpeg_capture_sequencer dut (
        .clk(clk), .reset(reset), .start_capture_in(start), .abort_in(abort),
        .frame_count_in(fcount), .timeout_in(timeout), .frame_valid_in(fv),
        .enc_data_in(enc_data), .enc_valid_in(enc_valid), .enc_last_in(enc_last),
        .enc_hold_out(hold), .enc_reset_out(enc_rst), .enc_en_out(enc_en),
        .data_out(dout), .data_valid_out(dvalid), .byte_count_out(bcount),
        .frames_done_out(fdone), .frame_done_out(fd_pulse), .image_valid_out(img),
        .error_out(err), .busy_out(busy)
    );

    jpeg_capture_sequencer #(.GAP_CYCLES(0), .SWAP_BYTES(1'b0)) dut_z (
        .clk(clk), .reset(reset), .start_capture_in(start_z), .abort_in(1'b0),
        .frame_count_in(fcount_z), .timeout_in(24'd0), .frame_valid_in(fv_z),
        .enc_data_in(enc_data_z), .enc_valid_in(enc_valid_z), .enc_last_in(enc_last_z),
        .enc_hold_out(hold_z), .enc_reset_out(enc_rst_z), .enc_en_out(enc_en_z),
        .data_out(dout_z), .data_valid_out(dvalid_z), .byte_count_out(bcount_z),
        .frames_done_out(fdone_z), .frame_done_out(fd_pulse_z), .image_valid_out(img_z),
        .error_out(err_z), .busy_out(busy_z)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int fd_pulses = 0;
    int consec = 0;
    bit prev_valid = 1'b0;

    logic          s_valid, s_hold, s_rst, s_en, s_fd, s_img, s_err, s_busy;
    logic [AW-1:0] s_bc;
    logic [FW-1:0] s_fdone;
    logic          z_valid, z_hold, z_en, z_img;
    logic [FW-1:0] z_fdone;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_z[$];
    logic [31:0] got_z[$];

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Samples both DUTs mid-cycle, then advances past the next rising edge.
    task automatic cycle_end();
        @(negedge clk);
        s_valid = dvalid;  s_hold = hold;  s_rst = enc_rst;  s_en = enc_en;
        s_fd = fd_pulse;   s_img = img;    s_err = err;      s_busy = busy;
        s_bc = bcount;     s_fdone = fdone;
        if (dvalid) begin
            got_q.push_back(dout);
            if (prev_valid) consec++;
        end
        prev_valid = dvalid;
        if (fd_pulse) fd_pulses++;
        z_valid = dvalid_z; z_hold = hold_z; z_en = enc_en_z; z_img = img_z; z_fdone = fdone_z;
        if (dvalid_z) got_z.push_back(dout_z);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle_end();
            if (s_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_beats(input int n, input logic [31:0] base, input logic [31:0] step,
                              input bit with_last, output bit ok);
        bit acc;
        ok = 1'b1;
        for (int b = 0; b < n; b++) begin
            enc_data  = base + step * b;
            enc_valid = 1'b1;
            enc_last  = with_last && (b == n - 1);
            exp_q.push_back(swap32(base + step * b));
            acc = 1'b0;
            for (int k = 0; k < 20 && !acc; k++) begin
                cycle_end();
                acc = s_valid;
            end
            if (!acc) ok = 1'b0;
        end
        enc_valid = 1'b0;
        enc_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle_end();
        cycle_end();
        reset = 1'b0;
        cycle_end();
        n_tests++; if (s_rst !== 1'b1) begin n_fail++; $display("FAIL reset_enc_reset got %b want 1", s_rst); end
        n_tests++; if ({s_valid, s_hold, s_en, s_fd, s_img, s_err, s_busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000000",
                               {s_valid, s_hold, s_en, s_fd, s_img, s_err, s_busy}); end
        n_tests++; if (s_bc !== 16'd0 || s_fdone !== 3'd0) begin
            n_fail++; $display("FAIL reset_counters got bc=%0d fd=%0d want 0/0", s_bc, s_fdone); end
        n_tests++; if (z_img !== 1'b0 || z_fdone !== 3'd0) begin
            n_fail++; $display("FAIL reset_z got img=%b fd=%0d want 0/0", z_img, z_fdone); end
    endtask

    task automatic test_zero_count();
        fcount = 3'd0;
        start  = 1'b1;
        cycle_end();
        cycle_end();
        start = 1'b0;
        cycle_end();
        n_tests++; if (s_busy !== 1'b0 || s_rst !== 1'b1) begin
            n_fail++; $display("FAIL zero_count got busy=%b rst=%b want 0/1", s_busy, s_rst); end
    endtask

    task automatic test_single_frame();
        int p0, c0;
        bit ok;
        logic [31:0] e, g;
        p0 = fd_pulses; c0 = consec;
        fcount = 3'd1; timeout = '0; start = 1'b1;
        cycle_end();
        start = 1'b0;
        wait_en(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_wait_sof got no enc_en want enc_en"); end
        fv = 1'b1;
        send_beats(5, 32'h11223344, 32'h0, 1'b1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_accept got stalled beat want all accepted"); end
        fv = 1'b0;
        cycle_end();
        cycle_end();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL t1_data got none want %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL t1_data got %h want %h", g, e); end
            end
        end
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t1_extra got %0d want 0", got_q.size()); got_q.delete(); end
        n_tests++; if (consec - c0 != 0) begin n_fail++; $display("FAIL t1_gap got %0d back-to-back want 0", consec - c0); end
        n_tests++; if (s_bc !== 16'd20) begin n_fail++; $display("FAIL t1_bytes got %0d want 20", s_bc); end
        n_tests++; if (fd_pulses - p0 != 1) begin n_fail++; $display("FAIL t1_pulses got %0d want 1", fd_pulses - p0); end
        n_tests++; if (s_img !== 1'b1 || s_fdone !== 3'd1) begin
            n_fail++; $display("FAIL t1_done got img=%b fd=%0d want 1/1", s_img, s_fdone); end
    endtask

    task automatic test_frame_in_progress();
        bit ok, rst_ok;
        logic [31:0] e, g;
        fv = 1'b1; fcount = 3'd1; start = 1'b1;
        cycle_end();
        start = 1'b0;
        enc_valid = 1'b1; enc_data = 32'hDEADBEEF;
        rst_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle_end();
            if (!s_rst || s_valid) rst_ok = 1'b0;
        end
        n_tests++; if (!rst_ok) begin n_fail++; $display("FAIL t2_hold_reset got released want held"); end
        enc_valid = 1'b0; fv = 1'b0;
        cycle_end();
        n_tests++; if (s_rst !== 1'b1) begin n_fail++; $display("FAIL t2_fall_cycle got %b want 1", s_rst); end
        cycle_end();
        n_tests++; if (s_rst !== 1'b0 || s_en !== 1'b1) begin
            n_fail++; $display("FAIL t2_wait_sof got rst=%b en=%b want 0/1", s_rst, s_en); end
        fv = 1'b1;
        send_beats(2, 32'h0A0B0C0D, 32'h01010101, 1'b1, ok);
        fv = 1'b0;
        cycle_end();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL t2_data got none want %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL t2_data got %h want %h", g, e); end
            end
        end
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t2_extra got %0d want 0", got_q.size()); got_q.delete(); end
        n_tests++; if (s_bc !== 16'd8 || s_img !== 1'b1) begin
            n_fail++; $display("FAIL t2_done got bc=%0d img=%b want 8/1", s_bc, s_img); end
    endtask

    task automatic test_burst();
        bit ok;
        logic [31:0] e, g;
        logic [FW-1:0] want_fd;
        fcount = 3'd3; start = 1'b1;
        cycle_end();
        start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_en(ok);
            n_tests++; if (!ok || s_bc !== 16'd0) begin
                n_fail++; $display("FAIL t3_sof%0d got en=%b bc=%0d want 1/0", f, ok, s_bc); end
            fv = 1'b1;
            send_beats(3, 32'hA0000000 + (f << 8), 32'h1, 1'b1, ok);
            fv = 1'b0;
            cycle_end();
            want_fd = 3'(f + 1);
            n_tests++; if (s_fd !== 1'b1 || s_fdone !== want_fd) begin
                n_fail++; $display("FAIL t3_count%0d got pulse=%b fd=%0d want 1/%0d", f, s_fd, s_fdone, want_fd); end
            n_tests++; if (s_rst !== (f < 2) || s_img !== (f == 2)) begin
                n_fail++; $display("FAIL t3_state%0d got rst=%b img=%b want %b/%b", f, s_rst, s_img, f < 2, f == 2); end
        end
        n_tests++; if (s_bc !== 16'd12) begin n_fail++; $display("FAIL t3_bytes got %0d want 12", s_bc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL t3_data got none want %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL t3_data got %h want %h", g, e); end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n_wait;
        fcount = 3'd1; timeout = 24'd100; fv = 1'b0; start = 1'b1;
        cycle_end();
        start = 1'b0;
        wait_en(ok);
        n_wait = ok ? 1 : 0;
        for (int k = 0; k < 300; k++) begin
            cycle_end();
            if (s_en) n_wait++;
            else break;
        end
        n_tests++; if (n_wait != 101) begin n_fail++; $display("FAIL t4_wait_cycles got %0d want 101", n_wait); end
        n_tests++; if (s_err !== 1'b1 || s_rst !== 1'b1 || s_busy !== 1'b0) begin
            n_fail++; $display("FAIL t4_error got err=%b rst=%b busy=%b want 1/1/0", s_err, s_rst, s_busy); end
        timeout = '0; start = 1'b1;
        cycle_end();
        start = 1'b0;
        wait_en(ok);
        n_tests++; if (!ok || s_err !== 1'b0) begin n_fail++; $display("FAIL t4_recover got en=%b err=%b want 1/0", ok, s_err); end
        fv = 1'b1;
        send_beats(1, 32'h00C0FFEE, 32'h0, 1'b1, ok);
        fv = 1'b0;
        cycle_end();
        n_tests++; if (s_img !== 1'b1 || exp_q.size() != 1 || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL t4_frame got img=%b beats=%0d want 1/1", s_img, got_q.size()); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_abort();
        bit ok;
        logic [31:0] e, g;
        fcount = 3'd1; start = 1'b1;
        cycle_end();
        start = 1'b0;
        wait_en(ok);
        fv = 1'b1;
        send_beats(3, 32'h55667788, 32'h10, 1'b0, ok);
        enc_valid = 1'b1; enc_data = 32'hCAFEF00D; abort = 1'b1;
        cycle_end();
        abort = 1'b0;
        cycle_end();
        n_tests++; if (s_valid !== 1'b0 || s_rst !== 1'b1) begin
            n_fail++; $display("FAIL t5_idle got valid=%b rst=%b want 0/1", s_valid, s_rst); end
        n_tests++; if (s_img !== 1'b0 || s_busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_flags got img=%b busy=%b want 0/0", s_img, s_busy); end
        enc_valid = 1'b0; fv = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin n_fail++; $display("FAIL t5_data got none want %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL t5_data got %h want %h", g, e); end
            end
        end
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t5_extra got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_back_to_back();
        bit acc, seen;
        logic [31:0] w, e, g;
        fcount_z = 3'd7; start_z = 1'b1;
        cycle_end();
        start_z = 1'b0;
        for (int f = 0; f < 4; f++) begin
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                cycle_end();
                seen = z_en;
            end
            n_tests++; if (!seen) begin n_fail++; $display("FAIL t6_sof%0d got no enc_en want enc_en", f); end
            fv_z = 1'b1;
            for (int b = 0; b < 4; b++) begin
                w = 32'h12340000 + (f << 8) + b;
                enc_data_z = w; enc_valid_z = 1'b1; enc_last_z = (b == 3);
                exp_z.push_back(w);
                if (b == 0) begin
                    acc = 1'b0;
                    for (int k = 0; k < 10 && !acc; k++) begin
                        cycle_end();
                        acc = z_valid;
                    end
                end else begin
                    cycle_end();
                    n_tests++; if (z_valid !== 1'b1 || z_hold !== 1'b0) begin
                        n_fail++; $display("FAIL t6_stream%0d_%0d got valid=%b hold=%b want 1/0", f, b, z_valid, z_hold); end
                end
            end
            enc_valid_z = 1'b0; enc_last_z = 1'b0; fv_z = 1'b0;
            cycle_end();
        end
        n_tests++; if (z_img !== 1'b1 || z_fdone !== 3'd4) begin
            n_fail++; $display("FAIL t6_clamp got img=%b fd=%0d want 1/4", z_img, z_fdone); end
        while (exp_z.size() > 0) begin
            e = exp_z.pop_front();
            n_tests++;
            if (got_z.size() == 0) begin n_fail++; $display("FAIL t6_data got none want %h", e); end
            else begin
                g = got_z.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL t6_data got %h want %h", g, e); end
            end
        end
        n_tests++; if (got_z.size() != 0) begin n_fail++; $display("FAIL t6_extra got %0d want 0", got_z.size()); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; fv = 1'b0; enc_valid = 1'b0; enc_last = 1'b0;
        fcount = '0; timeout = '0; enc_data = '0;
        start_z = 1'b0; fv_z = 1'b0; enc_valid_z = 1'b0; enc_last_z = 1'b0;
        fcount_z = '0; enc_data_z = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_zero_count();
        test_single_frame();
        test_frame_in_progress();
        test_burst();
        test_timeout();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
